// File: rtl/binary_adder_4bit_pkg.sv
// binary_adder_4bit_pkg: shared width default for the registered ripple adder
package binary_adder_4bit_pkg;
  localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/binary_adder_4bit_if.sv
// binary_adder_4bit_if: operand strobe and registered result bundle
interface binary_adder_4bit_if
  import binary_adder_4bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             overflow;
  logic             zero;
  logic             out_valid;
  modport master (
    output in_valid, a, b, c_in,
    input  s, c_out, overflow, zero, out_valid
  );
  modport slave (
    input  in_valid, a, b, c_in,
    output s, c_out, overflow, zero, out_valid
  );
endinterface

// File: rtl/binary_adder_4bit_full_adder.sv
// full_adder: 1-bit sum and majority carry cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

// File: rtl/binary_adder_4bit.sv
// binary_adder_4bit: ripple-carry adder with one-cycle registered sum and flags
module binary_adder_4bit
  import binary_adder_4bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst_n,
  binary_adder_4bit_if.slave bus
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  assign carry[0] = bus.c_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a(bus.a[i]),
      .b(bus.b[i]),
      .c_in(carry[i]),
      .s(sum[i]),
      .c_out(carry[i+1])
    );
  end
  // Result registers only load on a strobe, so idle-cycle garbage never reaches them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.s <= '0;
      bus.c_out <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.s <= sum;
        bus.c_out <= carry[WIDTH];
        bus.overflow <= carry[WIDTH] ^ carry[WIDTH-1];
        bus.zero <= ~|sum;
      end
    end
  end
endmodule

// File: tb/tb_binary_adder_4bit.sv
// tb_binary_adder_4bit: directed and exhaustive checks of the registered 4-bit adder
module tb_binary_adder_4bit;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  binary_adder_4bit_if #(.WIDTH(4)) bus ();
  binary_adder_4bit #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // {out_valid, c_out, overflow, zero, s}
  logic [7:0] obs;
  assign obs = {bus.out_valid, bus.c_out, bus.overflow, bus.zero, bus.s};
  task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic ci);
    bus.in_valid = v;
    bus.a = av;
    bus.b = bv;
    bus.c_in = ci;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 4'b1010, 4'b0101, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_%0d got=%b exp=%b", k, obs, 8'h00);
      end
    end
    rst_n = 1'b1;
    drive(1'b0, 4'b1010, 4'b0101, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_idle got=%b exp=%b", obs, 8'h00);
    end
  endtask
  task automatic test_carry_wrap;
    drive(1'b1, 4'b1111, 4'b0001, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs !== 8'b1101_0000) begin
      n_bad++;
      $display("FAIL carry_wrap got=%b exp=%b", obs, 8'b1101_0000);
    end
  endtask
  task automatic test_carry_in;
    drive(1'b1, 4'b0100, 4'b0001, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (obs !== 8'b1000_0110) begin
      n_bad++;
      $display("FAIL carry_in_a got=%b exp=%b", obs, 8'b1000_0110);
    end
    drive(1'b1, 4'b1001, 4'b0011, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (obs !== 8'b1000_1101) begin
      n_bad++;
      $display("FAIL carry_in_b got=%b exp=%b", obs, 8'b1000_1101);
    end
  endtask
  task automatic test_overflow;
    drive(1'b1, 4'b0111, 4'b0001, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs !== 8'b1010_1000) begin
      n_bad++;
      $display("FAIL overflow_pos got=%b exp=%b", obs, 8'b1010_1000);
    end
    drive(1'b1, 4'b1000, 4'b1000, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs !== 8'b1111_0000) begin
      n_bad++;
      $display("FAIL overflow_neg got=%b exp=%b", obs, 8'b1111_0000);
    end
  endtask
  task automatic test_hold;
    drive(1'b1, 4'b1111, 4'b1111, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (obs !== 8'b1100_1111) begin
      n_bad++;
      $display("FAIL max got=%b exp=%b", obs, 8'b1100_1111);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'(k), 4'(k + 5), 1'b0);
      @(negedge clk);
      n_cmp++;
      if (obs !== 8'b0100_1111) begin
        n_bad++;
        $display("FAIL hold_%0d got=%b exp=%b", k, obs, 8'b0100_1111);
      end
    end
  endtask
  task automatic test_reset_mid;
    rst_n = 1'b0;
    drive(1'b1, 4'b0011, 4'b0100, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid got=%b exp=%b", obs, 8'h00);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 8'b1000_0111) begin
      n_bad++;
      $display("FAIL after_reset got=%b exp=%b", obs, 8'b1000_0111);
    end
  endtask
  task automatic test_exhaustive;
    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++) begin
          logic [3:0] av, bv, se;
          logic [4:0] t;
          logic ov;
          av = 4'(ai);
          bv = 4'(bi);
          t = 5'(ai) + 5'(bi) + 5'(ci);
          se = t[3:0];
          ov = (av[3] == bv[3]) && (se[3] != av[3]);
          drive(1'b1, av, bv, 1'(ci));
          @(negedge clk);
          n_cmp++;
          if (obs !== {1'b1, t[4], ov, se == 4'd0, se}) begin
            n_bad++;
            $display("FAIL exh a=%h b=%h ci=%0d got=%b exp=%b", av, bv, ci, obs, {1'b1, t[4], ov, se == 4'd0, se});
          end
        end
  endtask
  initial begin
    test_reset;
    test_carry_wrap;
    test_carry_in;
    test_overflow;
    test_hold;
    test_reset_mid;
    test_exhaustive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
